// File: rtl/apb_req_arbiter_if.sv
// Bundle of the requester-side handshake and the APB master port of apb_req_arbiter.
// The master modport is the arbiter's view; the slave modport is the surrounding requesters/slave.
interface apb_req_arbiter_if #(
  parameter int NREQ = 4,
  parameter int NSLV = 4,
  parameter int AW   = 32,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_write;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ*4-1:0]  req_strb;
  logic [NREQ*3-1:0]  req_prot;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_rdata;
  logic               rsp_err;
  logic [NSLV-1:0]    psel;
  logic               penable;
  logic [AW-1:0]      paddr;
  logic               pwrite;
  logic [2:0]         pprot;
  logic [DW-1:0]      pwdata;
  logic [3:0]         pstrb;
  logic [DW-1:0]      prdata;
  logic               pready;
  logic               pslverr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
    input  prdata, pready, pslverr,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output psel, penable, paddr, pwrite, pprot, pwdata, pstrb
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
    output prdata, pready, pslverr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  psel, penable, paddr, pwrite, pprot, pwdata, pstrb
  );
endinterface

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter of NREQ requesters onto a single APB master port, with address-decoded
// psel, decode-error responses and an ACCESS-phase timeout against hung slaves.
module apb_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int NSLV    = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int SEL_LSB = 12,
  parameter int TIMEOUT = 16
) (
  input logic                 pclk,
  input logic                 preset,
  apb_req_arbiter_if.master   bus_if
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DECERR = 2'd3
  } state_e;

  function automatic logic [NREQ-1:0] req_onehot(input logic [PW-1:0] idx);
    logic [NREQ-1:0] v;
    v = '0;
    for (int i = 0; i < NREQ; i++) begin
      v[i] = (int'(idx) == i);
    end
    return v;
  endfunction

  function automatic logic [NSLV-1:0] sel_onehot(input logic [1:0] idx);
    logic [NSLV-1:0] v;
    v = '0;
    for (int i = 0; i < NSLV; i++) begin
      v[i] = (int'(idx) == i);
    end
    return v;
  endfunction

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   gnt_q, gnt_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NSLV-1:0] psel_q, psel_d;
  logic            penable_q, penable_d;
  logic [AW-1:0]   paddr_q, paddr_d;
  logic            pwrite_q, pwrite_d;
  logic [2:0]      pprot_q, pprot_d;
  logic [DW-1:0]   pwdata_q, pwdata_d;
  logic [3:0]      pstrb_q, pstrb_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;

  logic            gnt_found_s;
  logic [PW-1:0]   gnt_idx_s;
  logic            timeout_s;
  logic [1:0]      sel_idx_s;
  logic [AW-1:0]   new_addr_s;
  logic            new_write_s;

  // Round-robin search starting at the pointer; first valid requester wins.
  always_comb begin
    int  cand;
    logic hit;
    gnt_found_s = 1'b0;
    gnt_idx_s   = '0;
    cand        = 0;
    hit         = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand        = (int'(ptr_q) + k) % NREQ;
      hit         = bus_if.req_valid[cand] && !gnt_found_s;
      gnt_idx_s   = hit ? PW'(cand) : gnt_idx_s;
      gnt_found_s = gnt_found_s | hit;
    end
  end

  assign new_addr_s  = bus_if.req_addr[int'(gnt_idx_s)*AW +: AW];
  assign new_write_s = bus_if.req_write[gnt_idx_s];
  assign sel_idx_s   = new_addr_s[SEL_LSB+1:SEL_LSB];
  assign timeout_s   = (TIMEOUT != 0) && (int'(cnt_q) == TIMEOUT - 1);

  // Grant is only offered while the bus is idle.
  always_comb begin
    bus_if.req_ready = '0;
    if (state_q == S_IDLE && gnt_found_s) begin
      bus_if.req_ready = req_onehot(gnt_idx_s);
    end else begin
      bus_if.req_ready = '0;
    end
  end

  // Next-state and registered-output logic of the transfer sequencer.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pprot_d     = pprot_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (gnt_found_s) begin
          gnt_d    = gnt_idx_s;
          ptr_d    = (int'(gnt_idx_s) == NREQ - 1) ? '0 : gnt_idx_s + PW'(1);
          paddr_d  = new_addr_s;
          pwrite_d = new_write_s;
          pprot_d  = bus_if.req_prot[int'(gnt_idx_s)*3 +: 3];
          pwdata_d = bus_if.req_wdata[int'(gnt_idx_s)*DW +: DW];
          pstrb_d  = new_write_s ? bus_if.req_strb[int'(gnt_idx_s)*4 +: 4] : 4'h0;
          penable_d = 1'b0;
          if (int'(sel_idx_s) < NSLV) begin
            psel_d  = sel_onehot(sel_idx_s);
            state_d = S_SETUP;
          end else begin
            psel_d  = '0;
            state_d = S_DECERR;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        if (bus_if.pready) begin
          psel_d      = '0;
          penable_d   = 1'b0;
          state_d     = S_IDLE;
          rsp_valid_d = req_onehot(gnt_q);
          rsp_err_d   = bus_if.pslverr;
          rsp_rdata_d = pwrite_q ? '0 : bus_if.prdata;
        end else if (timeout_s) begin
          psel_d      = '0;
          penable_d   = 1'b0;
          state_d     = S_IDLE;
          rsp_valid_d = req_onehot(gnt_q);
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DECERR: begin
        rsp_valid_d = req_onehot(gnt_q);
        rsp_err_d   = 1'b1;
        state_d     = S_IDLE;
      end
      default: begin
        psel_d    = '0;
        penable_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any transfer in flight.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      cnt_q       <= '0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pprot_q     <= 3'b000;
      pwdata_q    <= '0;
      pstrb_q     <= 4'h0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      cnt_q       <= cnt_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pprot_q     <= pprot_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus_if.psel      = psel_q;
  assign bus_if.penable   = penable_q;
  assign bus_if.paddr     = paddr_q;
  assign bus_if.pwrite    = pwrite_q;
  assign bus_if.pprot     = pprot_q;
  assign bus_if.pwdata    = pwdata_q;
  assign bus_if.pstrb     = pstrb_q;
  assign bus_if.rsp_valid = rsp_valid_q;
  assign bus_if.rsp_rdata = rsp_rdata_q;
  assign bus_if.rsp_err   = rsp_err_q;
endmodule
